// File: rtl/aes_key_expand_pkg.sv
// Shared AES helpers: S-box, xtime and the block/round-count constants.
// Used by the key schedule and by the encryption core.
package aes_key_expand_pkg;

    localparam int unsigned AES_NB        = 4;
    localparam int unsigned AES_NR_OFFSET = 6;

    typedef enum logic {
        KS_IDLE   = 1'b0,
        KS_EXPAND = 1'b1
    } ks_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = x;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] subbytef(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_key_expand_word.sv
// Combinational key-schedule step: derives W[i] from W[i-1] and W[i-nk].
module aes_key_word
    import aes_key_expand_pkg::*;
#(
    parameter int unsigned nk = 8
) (
    input  logic [31:0] prev,
    input  logic [31:0] back,
    input  logic [2:0]  kmod,
    input  logic [7:0]  rcon,
    output logic [31:0] word
);

    logic        rot;
    logic        sub_only;
    logic [31:0] sin;
    logic [31:0] sub;

    always_comb begin
        rot      = (kmod == 3'd0);
        sub_only = (nk == 8) && (kmod == 3'd4);
        sin      = rot ? {prev[23:0], prev[31:24]} : prev;
        sub      = {subbytef(sin[31:24]), subbytef(sin[23:16]),
                    subbytef(sin[15:8]),  subbytef(sin[7:0])};
        if (rot) begin
            word = back ^ sub ^ {rcon, 24'h000000};
        end else if (sub_only) begin
            word = back ^ sub;
        end else begin
            word = back ^ prev;
        end
    end

endmodule

// File: rtl/aes_key_expand.sv
// Sequential AES key schedule: captures the key on start, then writes one
// schedule word per clock into the round-key bus consumed by the cipher core.
module aes_key_expand
    import aes_key_expand_pkg::*;
#(
    parameter int unsigned nk = 8,
    parameter int unsigned nb = AES_NB,
    parameter int unsigned nr = nk + AES_NR_OFFSET
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [32*nk-1:0]          key,
    output logic [32*nb*(nr+1)-1:0]   w,
    output logic                      busy,
    output logic                      done,
    output logic                      valid
);

    localparam int unsigned TOTAL = nb * (nr + 1);
    localparam int unsigned IDX_W = 6;

    if (!((nk == 4) || (nk == 6) || (nk == 8)) || (nb != AES_NB) ||
        (nr != nk + AES_NR_OFFSET)) begin : g_bad_param
        $error("aes_key_expand: nk must be 4, 6 or 8 with nb=4 and nr=nk+6");
    end

    ks_state_t          state, state_d;
    logic [IDX_W-1:0]   index, index_d;
    logic [2:0]         kmod, kmod_d;
    logic [7:0]         rcon, rcon_d;
    logic               done_d, valid_d;
    logic [31:0]        words   [TOTAL];
    logic [31:0]        words_d [TOTAL];
    logic [31:0]        new_word;

    aes_key_word #(.nk(nk)) u_word (
        .prev (words[index - IDX_W'(1)]),
        .back (words[index - IDX_W'(nk)]),
        .kmod (kmod),
        .rcon (rcon),
        .word (new_word)
    );

    // Next-state and next-schedule logic.
    always_comb begin
        state_d = state;
        index_d = index;
        kmod_d  = kmod;
        rcon_d  = rcon;
        done_d  = 1'b0;
        valid_d = valid;
        words_d = words;
        case (state)
            KS_IDLE: begin
                if (start) begin
                    for (int i = 0; i < TOTAL; i++) words_d[i] = '0;
                    for (int i = 0; i < nk; i++) words_d[i] = key[32*(nk-1-i) +: 32];
                    state_d = KS_EXPAND;
                    index_d = IDX_W'(nk);
                    kmod_d  = 3'd0;
                    rcon_d  = 8'h01;
                    valid_d = 1'b0;
                end
            end
            KS_EXPAND: begin
                words_d[index] = new_word;
                index_d = index + IDX_W'(1);
                kmod_d  = (kmod == 3'(nk - 1)) ? 3'd0 : kmod + 3'd1;
                if (kmod == 3'd0) rcon_d = xtime(rcon);
                if (index == IDX_W'(TOTAL - 1)) begin
                    state_d = KS_IDLE;
                    index_d = '0;
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                end
            end
            default: state_d = KS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= KS_IDLE;
            index <= '0;
            kmod  <= 3'd0;
            rcon  <= 8'h01;
            busy  <= 1'b0;
            done  <= 1'b0;
            valid <= 1'b0;
            for (int i = 0; i < TOTAL; i++) words[i] <= '0;
        end else begin
            state <= state_d;
            index <= index_d;
            kmod  <= kmod_d;
            rcon  <= rcon_d;
            busy  <= (state_d == KS_EXPAND);
            done  <= done_d;
            valid <= valid_d;
            words <= words_d;
        end
    end

    for (genvar g = 0; g < TOTAL; g++) begin : g_bus
        assign w[32*g +: 32] = words[g];
    end

endmodule
